multicycle_control_fsm: RTL and testbench

//  Multi-cycle main control unit for the MIPS-subset datapath. It replaces the single-cycle

---
 rtl/multicycle_control_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control unit for the MIPS-subset datapath.
// Registered state drives all datapath controls.
// Memory states stall on mem_ready and are guarded by a wait-timeout counter.
// Illegal encodings or a timeout park the FSM in a sticky FAULT state that only reset_n clears.
module multicycle_control_fsm #(
  parameter int ALUOP_W     = 3,
  parameter int STATE_W     = 4,
  parameter int WAIT_MAX    = 15,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               alu_le_zero,
  input  logic               alu_v,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               fault,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC   = STATE_W'(6),
    S_ALUWB  = STATE_W'(7),
    S_BRANCH = STATE_W'(8),
    S_JUMP   = STATE_W'(9),
    S_IMMEX  = STATE_W'(10),
    S_IMMWB  = STATE_W'(11),
    S_BLEZ   = STATE_W'(12),
    S_BRV    = STATE_W'(13),
    S_FAULT  = STATE_W'(15)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_NANDI = 6'b010000;
  localparam logic [5:0] OP_BLEZ  = 6'b100100;
  localparam logic [5:0] FN_BRV   = 6'b010100;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FN   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_NAND = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_PASS = ALUOP_W'(3'b111);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_rdy;
  logic       in_wait_state;
  logic       r_funct_legal;
  logic       timeout;

  // alu_zero is qualified against pc_write_cond inside the datapath; sequencing ignores it
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  assign mem_rdy       = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign r_funct_legal = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign timeout       = in_wait_state && !mem_rdy && (wait_cnt_q == WAIT_LIMIT);
  assign dbg_state     = state_q;

  // Next-state sequencing; a timeout overrides any stall
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct == FN_BRV)    state_d = S_BRV;
            else if (r_funct_legal) state_d = S_EXEC;
            else                    state_d = S_FAULT;
          end
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_NANDI: state_d = S_IMMEX;
          OP_BLEZ:  state_d = S_BLEZ;
          default:  state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FAULT;
      end
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_BLEZ:   state_d = S_FETCH;
      S_BRV:    state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  // Wait counter: cleared on every state change, counts stalled cycles while held
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)             wait_cnt_d = 8'd0;
    else if (in_wait_state && !mem_rdy) wait_cnt_d = wait_cnt_q + 8'd1;
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Control decode from current state; everything held at 0 while reset_n is low
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    pc_source     = 2'd0;
    fault         = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_rdy;
          pc_write  = mem_rdy;
        end
        S_DECODE: alu_src_b = 2'd3;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FN;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'd1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = ALU_NAND;
        end
        S_IMMWB: reg_write = 1'b1;
        S_BLEZ: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_write   = alu_le_zero;
          reg_write  = alu_le_zero;
          pc_source  = 2'd1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        S_BRV: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_PASS;
          pc_write  = alu_v;
          pc_source = 2'd3;
        end
        S_FAULT: fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one-cycle vectors pushed to a scoreboard queue when driven,
// popped and compared against the DUT outputs one time unit later.
module tb_multicycle_control_fsm;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       mem_ready = 1'b0, alu_zero = 1'b0, alu_le_zero = 1'b0, alu_v = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, fault;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] dbg_state;

  multicycle_control_fsm #(
    .ALUOP_W(3), .STATE_W(4), .WAIT_MAX(WAIT_MAX), .MEM_WAIT_EN(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_le_zero(alu_le_zero), .alu_v(alu_v),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .fault(fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Opcodes / functs
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_NANDI = 6'b010000;
  localparam logic [5:0] OP_BLZ = 6'b100100, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_BRV = 6'b010100, FN_BAD = 6'b000111;

  // Strobes {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write}
  localparam logic [6:0] B_NONE = 7'b0000000, B_FETCH = 7'b1001010, B_FWAIT = 7'b0001000;
  localparam logic [6:0] B_MEMRD = 7'b0011000, B_MEMWR = 7'b0010100, B_REGW = 7'b0000001;
  localparam logic [6:0] B_PCWC = 7'b0100000, B_PCW = 7'b1000000, B_LINK = 7'b1000001;

  // Selects {reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [11:0] SEL_ZERO  = 12'b00_00_0_00_000_00;
  localparam logic [11:0] SEL_FETCH = 12'b00_00_0_01_000_00;
  localparam logic [11:0] SEL_DEC   = 12'b00_00_0_11_000_00;
  localparam logic [11:0] SEL_MADR  = 12'b00_00_1_10_000_00;
  localparam logic [11:0] SEL_MWB   = 12'b00_01_0_00_000_00;
  localparam logic [11:0] SEL_EXE   = 12'b00_00_1_00_100_00;
  localparam logic [11:0] SEL_AWB   = 12'b01_00_0_00_000_00;
  localparam logic [11:0] SEL_BR    = 12'b00_00_1_00_001_01;
  localparam logic [11:0] SEL_JMP   = 12'b00_00_0_00_000_10;
  localparam logic [11:0] SEL_IMM   = 12'b00_00_1_10_011_00;
  localparam logic [11:0] SEL_BLZ   = 12'b10_10_1_00_001_01;
  localparam logic [11:0] SEL_BRV   = 12'b00_00_1_00_111_11;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic        le;
    logic        v;
    logic [3:0]  st;
    logic [6:0]  stb;
    logic [11:0] sel;
    logic        flt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string n, input logic [5:0] op, input logic [5:0] fn,
                              input logic rdy, input logic le, input logic v,
                              input logic [3:0] st, input logic [6:0] stb,
                              input logic [11:0] sel, input logic flt);
    vec_t r;
    r.name = n; r.op = op; r.fn = fn; r.rdy = rdy; r.le = le; r.v = v;
    r.st = st; r.stb = stb; r.sel = sel; r.flt = flt;
    return r;
  endfunction

  task automatic check_out();
    vec_t        e;
    logic [6:0]  stb_act;
    logic [11:0] sel_act;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    stb_act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write};
    sel_act = {reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
    checks++;
    if (dbg_state !== e.st) begin
      errors++;
      $display("FAIL %s state got %0d want %0d", e.name, dbg_state, e.st);
    end
    checks++;
    if (stb_act !== e.stb) begin
      errors++;
      $display("FAIL %s strobes got %b want %b", e.name, stb_act, e.stb);
    end
    checks++;
    if (sel_act !== e.sel) begin
      errors++;
      $display("FAIL %s selects got %b want %b", e.name, sel_act, e.sel);
    end
    checks++;
    if (fault !== e.flt) begin
      errors++;
      $display("FAIL %s fault got %b want %b", e.name, fault, e.flt);
    end
    $display("vec %-14s state=%0d strobes=%b selects=%b fault=%b", e.name, dbg_state, stb_act, sel_act, fault);
  endtask

  // One clock cycle: drive at the falling edge, check after a settle delay
  task automatic drive(input vec_t v);
    @(negedge clk);
    opcode      = v.op;
    funct       = v.fn;
    mem_ready   = v.rdy;
    alu_le_zero = v.le;
    alu_v       = v.v;
    alu_zero    = 1'($urandom_range(0, 1));
    exp_q.push_back(v);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    exp_q.push_back(mk("reset", OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, B_NONE, SEL_ZERO, 1'b0));
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // lw
    tbl.push_back(mk("lw.fetch",   OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("lw.decode",  OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("lw.memadr",  OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd2, B_NONE,  SEL_MADR,  1'b0));
    tbl.push_back(mk("lw.memrd",   OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd3, B_MEMRD, SEL_ZERO,  1'b0));
    tbl.push_back(mk("lw.memwb",   OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd4, B_REGW,  SEL_MWB,   1'b0));
    // sw
    tbl.push_back(mk("sw.fetch",   OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("sw.decode",  OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("sw.memadr",  OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd2, B_NONE,  SEL_MADR,  1'b0));
    tbl.push_back(mk("sw.memwr",   OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd5, B_MEMWR, SEL_ZERO,  1'b0));
    // R-type add
    tbl.push_back(mk("add.fetch",  OP_R, FN_ADD, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("add.decode", OP_R, FN_ADD, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("add.exec",   OP_R, FN_ADD, 1'b1, 1'b0, 1'b0, 4'd6, B_NONE,  SEL_EXE,   1'b0));
    tbl.push_back(mk("add.aluwb",  OP_R, FN_ADD, 1'b1, 1'b0, 1'b0, 4'd7, B_REGW,  SEL_AWB,   1'b0));
    // beq
    tbl.push_back(mk("beq.fetch",  OP_BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("beq.decode", OP_BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("beq.branch", OP_BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd8, B_PCWC,  SEL_BR,    1'b0));
    // j
    tbl.push_back(mk("j.fetch",    OP_J, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("j.decode",   OP_J, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("j.jump",     OP_J, 6'd0, 1'b1, 1'b0, 1'b0, 4'd9, B_PCW,   SEL_JMP,   1'b0));
    // nandi
    tbl.push_back(mk("nandi.fetch", OP_NANDI, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("nandi.dec",   OP_NANDI, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("nandi.immex", OP_NANDI, 6'd0, 1'b1, 1'b0, 1'b0, 4'd10, B_NONE,  SEL_IMM,   1'b0));
    tbl.push_back(mk("nandi.immwb", OP_NANDI, 6'd0, 1'b1, 1'b0, 1'b0, 4'd11, B_REGW,  SEL_ZERO,  1'b0));
    // blezal not taken, then taken
    tbl.push_back(mk("blz0.fetch", OP_BLZ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("blz0.dec",   OP_BLZ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("blz0.blez",  OP_BLZ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd12, B_NONE,  SEL_BLZ,   1'b0));
    tbl.push_back(mk("blz1.fetch", OP_BLZ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("blz1.dec",   OP_BLZ, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("blz1.blez",  OP_BLZ, 6'd0, 1'b1, 1'b1, 1'b0, 4'd12, B_LINK,  SEL_BLZ,   1'b0));
    // brv with overflow, then without
    tbl.push_back(mk("brv1.fetch", OP_R, FN_BRV, 1'b1, 1'b0, 1'b1, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("brv1.dec",   OP_R, FN_BRV, 1'b1, 1'b0, 1'b1, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("brv1.brv",   OP_R, FN_BRV, 1'b1, 1'b0, 1'b1, 4'd13, B_PCW,   SEL_BRV,   1'b0));
    tbl.push_back(mk("brv0.fetch", OP_R, FN_BRV, 1'b1, 1'b0, 1'b0, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    tbl.push_back(mk("brv0.dec",   OP_R, FN_BRV, 1'b1, 1'b0, 1'b0, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    tbl.push_back(mk("brv0.brv",   OP_R, FN_BRV, 1'b1, 1'b0, 1'b0, 4'd13, B_NONE,  SEL_BRV,   1'b0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // sw with mem_ready low for three MEMWR cycles: mem_write held four cycles
    drive(mk("sws.fetch",  OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    drive(mk("sws.decode", OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    drive(mk("sws.memadr", OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd2, B_NONE,  SEL_MADR,  1'b0));
    for (int i = 0; i < 3; i++)
      drive(mk("sws.stall", OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd5, B_MEMWR, SEL_ZERO, 1'b0));
    drive(mk("sws.done",   OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd5, B_MEMWR, SEL_ZERO,  1'b0));
    drive(mk("sws.next",   OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, B_FWAIT, SEL_FETCH, 1'b0));

    // reset_n asserted mid-MEMWR: mem_write drops without waiting for a clock
    do_reset();
    drive(mk("swr.fetch",  OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));
    drive(mk("swr.decode", OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    drive(mk("swr.memadr", OP_SW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd2, B_NONE,  SEL_MADR,  1'b0));
    drive(mk("swr.memwr",  OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd5, B_MEMWR, SEL_ZERO,  1'b0));
    #1;
    reset_n = 1'b0;
    exp_q.push_back(mk("swr.inreset", OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, B_NONE, SEL_ZERO, 1'b0));
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(mk("swr.after",  OP_SW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, B_FWAIT, SEL_FETCH, 1'b0));

    // mem_ready arrives in the cycle the counter hits WAIT_MAX: completion wins
    do_reset();
    for (int i = 0; i < WAIT_MAX; i++)
      drive(mk("win.wait", OP_J, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, B_FWAIT, SEL_FETCH, 1'b0));
    drive(mk("win.ready",  OP_J, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1 - 4'd1, B_FETCH, SEL_FETCH, 1'b0));
    drive(mk("win.decode", OP_J, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1, B_NONE,  SEL_DEC,   1'b0));
    drive(mk("win.jump",   OP_J, 6'd0, 1'b1, 1'b0, 1'b0, 4'd9, B_PCW,   SEL_JMP,   1'b0));

    // FETCH starved for WAIT_MAX+1 cycles: sticky FAULT until reset
    do_reset();
    for (int i = 0; i <= WAIT_MAX; i++)
      drive(mk("to.wait", OP_LW, 6'd0, 1'b0, 1'b0, 1'b0, 4'd0, B_FWAIT, SEL_FETCH, 1'b0));
    for (int i = 0; i < 3; i++)
      drive(mk("to.fault", OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd15, B_NONE, SEL_ZERO, 1'b1));
    do_reset();
    drive(mk("to.recover", OP_LW, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0, B_FETCH, SEL_FETCH, 1'b0));

    // Illegal opcode
    do_reset();
    drive(mk("badop.fetch", OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    drive(mk("badop.dec",   OP_BAD, 6'd0, 1'b1, 1'b0, 1'b0, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    for (int i = 0; i < 2; i++)
      drive(mk("badop.fault", OP_BAD, 6'd0, 1'b1, 1'b1, 1'b1, 4'd15, B_NONE, SEL_ZERO, 1'b1));

    // Illegal R-type funct
    do_reset();
    drive(mk("badfn.fetch", OP_R, FN_BAD, 1'b1, 1'b0, 1'b0, 4'd0,  B_FETCH, SEL_FETCH, 1'b0));
    drive(mk("badfn.dec",   OP_R, FN_BAD, 1'b1, 1'b0, 1'b0, 4'd1,  B_NONE,  SEL_DEC,   1'b0));
    for (int i = 0; i < 2; i++)
      drive(mk("badfn.fault", OP_R, FN_BAD, 1'b1, 1'b1, 1'b1, 4'd15, B_NONE, SEL_ZERO, 1'b1));

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
